// File: rtl/opa_issue_ctrl.sv
// ID->EX operand-A issue controller: decodes the source select, holds one issued
// instruction in a valid/ready output slice, and inserts load-use bubbles.
// Optional perf counters are enabled with the OPA_PERF_CNT_EN macro.
module opa_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_uidetect,
    output logic [WIDTH-1:0] o_pc,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rd,
    output logic             o_is_load,
    output logic [CNT_W-1:0] o_auipc_cnt,
    output logic [CNT_W-1:0] o_lui_cnt
);
    localparam int HZ_W = (LU_STALL < 1) ? 1 : $clog2(LU_STALL + 1);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [1:0]        uid_q, uid_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rd_q, rd_d;
    logic              ld_q, ld_d;
    logic [4:0]        hz_rd_q, hz_rd_d;
    logic [HZ_W-1:0]   hz_cnt_q, hz_cnt_d;

    logic [6:0] opc;
    logic [1:0] dec_uid;
    logic       dec_rs1_used;
    logic       hazard;
    logic       accept;
    logic       drain;
    logic       unused_instr_bits;

    assign opc               = i_instr[6:0];
    assign unused_instr_bits = ^{i_instr[31:20], i_instr[14:12]};

    always_comb begin
        dec_uid      = 2'b00;
        dec_rs1_used = 1'b0;
        if (opc == OP_LUI) begin
            dec_uid = 2'b10;
        end else if (opc == OP_AUIPC) begin
            dec_uid = 2'b01;
        end else begin
            case (opc)
                7'b0110011, 7'b0010011, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1100111: dec_rs1_used = 1'b1;
                default:                            dec_rs1_used = 1'b0;
            endcase
        end
    end

    // x0 never creates a dependency, and a zero stall depth disables the check.
    assign hazard = (LU_STALL != 0) && (hz_cnt_q != '0) && dec_rs1_used &&
                    (i_instr[19:15] == hz_rd_q) && (i_instr[19:15] != 5'd0);

    assign o_out_valid = (state_q == S_FULL);
    assign o_in_ready  = !i_rst && !i_flush && (!o_out_valid || i_out_ready) && !hazard;
    assign accept      = i_in_valid && o_in_ready;
    assign drain       = o_out_valid && i_out_ready;

    always_comb begin
        state_d  = state_q;
        uid_d    = uid_q;
        pc_d     = pc_q;
        rs1_d    = rs1_q;
        rd_d     = rd_q;
        ld_d     = ld_q;
        hz_rd_d  = hz_rd_q;
        hz_cnt_d = hz_cnt_q;

        if (i_flush) begin
            state_d  = S_EMPTY;
            hz_cnt_d = '0;
        end else begin
            if (accept) begin
                state_d = S_FULL;
                uid_d   = dec_uid;
                pc_d    = i_pc;
                rs1_d   = (dec_uid == 2'b00) ? i_instr[19:15] : 5'd0;
                rd_d    = i_instr[11:7];
                ld_d    = (opc == OP_LOAD);
            end else if (drain) begin
                state_d = S_EMPTY;
            end

            // A fresh load drain restarts the window rather than decrementing it.
            if (drain && ld_q && (rd_q != 5'd0)) begin
                hz_rd_d  = rd_q;
                hz_cnt_d = HZ_W'(LU_STALL);
            end else if (hz_cnt_q != '0) begin
                hz_cnt_d = hz_cnt_q - HZ_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_EMPTY;
            uid_q    <= 2'b00;
            pc_q     <= '0;
            rs1_q    <= 5'd0;
            rd_q     <= 5'd0;
            ld_q     <= 1'b0;
            hz_rd_q  <= 5'd0;
            hz_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            uid_q    <= uid_d;
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rd_q     <= rd_d;
            ld_q     <= ld_d;
            hz_rd_q  <= hz_rd_d;
            hz_cnt_q <= hz_cnt_d;
        end
    end

    assign o_uidetect = uid_q;
    assign o_pc       = pc_q;
    assign o_rs1      = rs1_q;
    assign o_rd       = rd_q;
    assign o_is_load  = ld_q;

`ifdef OPA_PERF_CNT_EN
    logic [CNT_W-1:0] auipc_cnt_q, auipc_cnt_d;
    logic [CNT_W-1:0] lui_cnt_q, lui_cnt_d;

    // Saturating counts of issued PC/zero selects; flush does not clear them.
    always_comb begin
        auipc_cnt_d = auipc_cnt_q;
        lui_cnt_d   = lui_cnt_q;
        if (drain && !i_flush) begin
            if (uid_q == 2'b01 && auipc_cnt_q != '1) auipc_cnt_d = auipc_cnt_q + CNT_W'(1);
            if (uid_q == 2'b10 && lui_cnt_q != '1)   lui_cnt_d   = lui_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            auipc_cnt_q <= '0;
            lui_cnt_q   <= '0;
        end else begin
            auipc_cnt_q <= auipc_cnt_d;
            lui_cnt_q   <= lui_cnt_d;
        end
    end

    assign o_auipc_cnt = auipc_cnt_q;
    assign o_lui_cnt   = lui_cnt_q;
`else
    assign o_auipc_cnt = '0;
    assign o_lui_cnt   = '0;
`endif

endmodule

// File: tb/tb_opa_issue_ctrl.sv
// Scoreboard bench for opa_issue_ctrl: directed instructions push hand-computed
// expectations; a negedge monitor pops and compares on every slice drain.
module tb_opa_issue_ctrl;
    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, is_load;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc, o_pc;
    logic [1:0]       uid;
    logic [4:0]       rs1, rd;
    logic [CNT_W-1:0] acnt, lcnt;

    opa_issue_ctrl #(.WIDTH(WIDTH), .LU_STALL(1), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_instr(instr), .i_pc(pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_uidetect(uid), .o_pc(o_pc), .o_rs1(rs1), .o_rd(rd), .o_is_load(is_load),
        .o_auipc_cnt(acnt), .o_lui_cnt(lcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  uid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   drain_cyc = 0;
    int   last_wait = 0;
    int   exp_l[5];

    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_ADD5  = 32'h00028333;
    localparam logic [31:0] I_ADD7  = 32'h00038333;
    localparam logic [31:0] I_LW    = 32'h0002A283;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every drain pops the oldest expected issue.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            drain_cyc = cyc;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL drain_unexpected: got pc %h expected no output", o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("uidetect", 32'(uid), 32'(e.uid));
                chk("pc", o_pc, e.pc);
                chk("rs1", 32'(rs1), 32'(e.rs1));
                chk("rd", 32'(rd), 32'(e.rd));
                chk("is_load", 32'(is_load), 32'(e.ld));
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] p, input exp_t e);
        bit ok;
        int w;
        ok = 1'b0;
        w  = 0;
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        while (!ok && w < 20) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
            end else begin
                w++;
                @(posedge clk); #1;
            end
        end
        last_wait = w;
        if (ok) begin
            sb.push_back(e);
            acc_cyc = cyc;
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got no accept expected accept pc %h", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        instr    = 32'h0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
`ifdef OPA_PERF_CNT_EN
        exp_l = '{1, 2, 3, 3, 3};
`else
        exp_l = '{0, 0, 0, 0, 0};
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; instr = I_LUI; pc = 32'h100; out_ready = 1'b1;

        // Reset held two cycles while decode offers an instruction
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_uid", 32'(uid), 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_rs1", 32'(rs1), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_ld", 32'(is_load), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;

        // LUI: valid the cycle after accept, rs1 forced to 0
        issue(I_LUI, 32'h100, exp_t'{2'b10, 32'h100, 5'd0, 5'd1, 1'b0});
        idle();
        @(negedge clk);
        chk("lui_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        // AUIPC then ADD back-to-back, one per cycle
        issue(I_AUIPC, 32'h200, exp_t'{2'b01, 32'h200, 5'd0, 5'd1, 1'b0});
        a0 = acc_cyc;
        issue(I_ADD5, 32'h204, exp_t'{2'b00, 32'h204, 5'd5, 5'd6, 1'b0});
        chk("b2b_spacing", 32'(acc_cyc - a0), 1);
        idle();
        repeat (2) begin @(posedge clk); #1; end

        // LW x5 then dependent ADD x6,x5: one bubble
        issue(I_LW, 32'h300, exp_t'{2'b00, 32'h300, 5'd5, 5'd5, 1'b1});
        idle();
        @(posedge clk); #1;
        issue(I_ADD5, 32'h304, exp_t'{2'b00, 32'h304, 5'd5, 5'd6, 1'b0});
        chk("lu_bubble", 32'(last_wait), 1);
        chk("lu_accept_after_drain", 32'(acc_cyc - drain_cyc), 2);
        idle();
        repeat (2) begin @(posedge clk); #1; end

        // LW x5 then independent ADD x6,x7: no bubble
        issue(I_LW, 32'h310, exp_t'{2'b00, 32'h310, 5'd5, 5'd5, 1'b1});
        idle();
        @(posedge clk); #1;
        issue(I_ADD7, 32'h314, exp_t'{2'b00, 32'h314, 5'd7, 5'd6, 1'b0});
        chk("no_bubble", 32'(last_wait), 0);
        idle();
        repeat (2) begin @(posedge clk); #1; end

        // Back-pressure: held slice stays stable, then flush empties it
        out_ready = 1'b0;
        issue(I_AUIPC, 32'h400, exp_t'{2'b01, 32'h400, 5'd0, 5'd1, 1'b0});
        in_valid = 1'b1; instr = I_ADD7; pc = 32'h404;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_uid", 32'(uid), 32'(2'b01));
            chk("hold_pc", o_pc, 32'h400);
            chk("hold_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        sb.delete();
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Reset while an instruction is held discards it
        issue(I_LUI, 32'h500, exp_t'{2'b10, 32'h500, 5'd0, 5'd1, 1'b0});
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_pc", o_pc, 0);
        chk("rst_mid_lcnt", 32'(lcnt), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Five LUIs: saturating counter when enabled, zero otherwise
        for (int k = 0; k < 5; k++) begin
            issue(I_LUI, 32'h600 + 32'(4 * k), exp_t'{2'b10, 32'h600 + 32'(4 * k), 5'd0, 5'd1, 1'b0});
            idle();
            @(posedge clk); #1;
            @(negedge clk);
            chk("lui_cnt", 32'(lcnt), 32'(exp_l[k]));
            @(posedge clk); #1;
        end
        chk("auipc_cnt", 32'(acnt), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
